// File: rtl/riscv_isa_pkg.sv
// Shared ISA types for the front end.
//   INSTRUCTION         : one 32-bit instruction word as returned by the I-cache.
//   INSTRUCTION_FECHED  : fetched instruction tagged with its pc and pc+4, as handed to decode.
//   FETCH_RESET_PC      : default pc loaded into the fetch stage at reset.
package riscv_isa;

  localparam int unsigned ISA_XLEN = 32;

  typedef logic [31:0] INSTRUCTION;

  typedef struct packed {
    INSTRUCTION            instruction;
    logic [ISA_XLEN-1:0]   pc;
    logic [ISA_XLEN-1:0]   pc_4;
  } INSTRUCTION_FECHED;

  localparam logic [ISA_XLEN-1:0] FETCH_RESET_PC = '0;

endpackage

// File: rtl/fetch_fifo.sv
// Parametrised synchronous FIFO used by the fetch stage.
//   clk, reset        : clock, asynchronous active-low reset
//   push, push_data   : write strobe and data (ignored when full unless popping the same cycle)
//   pop               : read strobe (ignored when empty)
//   flush             : empties the FIFO; wins over push and pop
//   head_data         : oldest entry (registered storage, no write-through bypass)
//   full, empty, count: occupancy status
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(DEPTH));
  assign do_pop    = pop & ~empty;
  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (do_push) begin
          mem_q[wr_ptr_q] <= push_data;
          wr_ptr_q        <= ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
          rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues in-order pipelined I-cache requests and queues the returned
// instructions (with pc and pc+4) for decode.
//   clk, reset                : clock, asynchronous active-low reset
//   jump, jump_addr           : redirect strobe and target from execute
//   cache_req_*               : request channel (addr is the current pc)
//   cache_rsp_valid/_data     : in-order responses, one per accepted request
//   decode_instruction_*      : queue head and its valid; decode_ready consumes it
//   queue_count               : current queue occupancy
module fetch_queue
  import riscv_isa::*;
#(
  parameter int unsigned     XLEN            = ISA_XLEN,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = FETCH_RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   jump,
  input  logic [XLEN-1:0]        jump_addr,
  output logic                   cache_req_valid,
  output logic [XLEN-1:0]        cache_req_addr,
  input  logic                   cache_req_ready,
  input  logic                   cache_rsp_valid,
  input  INSTRUCTION             cache_rsp_data,
  output INSTRUCTION_FECHED      decode_instruction_data,
  output logic                   decode_instruction_valid,
  input  logic                   decode_ready,
  output logic [$clog2(DEPTH):0] queue_count
);

  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned OutW   = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned SumW   = CntW + 1;
  localparam int unsigned EntryW = $bits(INSTRUCTION_FECHED);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [OutW-1:0]   inflight_q, inflight_d;
  logic [OutW-1:0]   drop_q, drop_d;
  logic [SumW-1:0]   occupancy;
  logic              req_fire, rsp_keep, queue_empty;
  logic [XLEN-1:0]   pend_pc;
  INSTRUCTION_FECHED rsp_entry;
  logic [EntryW-1:0] queue_head;

  logic                      unused_status;
  logic                      queue_full, pend_full, pend_empty;
  logic [$clog2(MAX_OUTSTANDING):0] pend_count;

  // Credit covers both the in-flight requests and the queued entries, so every accepted request
  // already owns a queue slot when its response returns.
  assign occupancy       = SumW'(inflight_q) + SumW'(queue_count);
  assign cache_req_valid = reset & ~jump & (inflight_q < OutW'(MAX_OUTSTANDING))
                           & (occupancy < SumW'(DEPTH));
  assign cache_req_addr  = pc_q;
  assign req_fire        = cache_req_valid & cache_req_ready;
  // A response in the jump cycle belongs to the old path and is never counted in drop.
  assign rsp_keep        = cache_rsp_valid & ~jump & (drop_q == '0);

  assign rsp_entry.instruction = cache_rsp_data;
  assign rsp_entry.pc          = pend_pc;
  assign rsp_entry.pc_4        = pend_pc + XLEN'(4);

  assign decode_instruction_valid = ~queue_empty;
  assign decode_instruction_data  = INSTRUCTION_FECHED'(queue_head);

  assign unused_status = ^{queue_full, pend_full, pend_empty, pend_count};

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + OutW'(req_fire) - OutW'(cache_rsp_valid);
    drop_d     = drop_q;
    if (jump) begin
      pc_d   = jump_addr;
      drop_d = inflight_d;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + XLEN'(4);
      end
      if (cache_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - OutW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // Address of each accepted request, consumed by its (possibly dropped) response.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pending_pc (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (cache_rsp_valid),
    .flush     (1'b0),
    .head_data (pend_pc),
    .full      (pend_full),
    .empty     (pend_empty),
    .count     (pend_count)
  );

  fetch_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_instr_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_keep),
    .push_data (rsp_entry),
    .pop       (decode_instruction_valid & decode_ready),
    .flush     (jump),
    .head_data (queue_head),
    .full      (queue_full),
    .empty     (queue_empty),
    .count     (queue_count)
  );

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Next-generation instruction fetch stage. Issues in-order, pipelined requests to an instruction cache with variable response latency, and tolerates up to MAX_OUTSTANDING in-flight requests.
- Buffers returned instructions with their pc and pc+4 in a DEPTH-entry queue that feeds decode through a valid/ready handshake.
- On a jump, flushes the queue, redirects the PC and silently drops responses still in flight from the old path.

Parameters:
- XLEN, 32, width of PC and addresses.
- DEPTH, 4, fetch queue entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum cache requests in flight (power of two, >=1, <=DEPTH).
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- jump  in  1  redirect strobe from execute.
- jump_addr  in  XLEN  redirect target.
- cache_req_valid  out  1  fetch request valid.
- cache_req_addr  out  XLEN  fetch address (equals pc_reg).
- cache_req_ready  in  1  cache accepts request.
- cache_rsp_valid  in  1  response valid; responses arrive in request order, one per accepted request.
- cache_rsp_data  in  INSTRUCTION  returned instruction word.
- decode_instruction_data  out  INSTRUCTION_FECHED  {instruction, pc, pc_4} at queue head.
- decode_instruction_valid  out  1  head entry valid.
- decode_ready  in  1  decode consumes head when valid.
- queue_count  out  $clog2(DEPTH)+1  current occupancy (debug/perf).

Behaviour:
- Reset (reset=0, async): pc_reg=RESET_PC; queue empty; inflight=0; drop=0; cache_req_valid=0; decode_instruction_valid=0; queue_count=0; decode_instruction_data=0.
- Credit rule: cache_req_valid = !jump & (inflight < MAX_OUTSTANDING) & (inflight + queue_count < DEPTH). Every accepted request is therefore guaranteed a queue slot. A response never overflows the queue.
- Request accept (valid & ready): pc_reg <= pc_reg + 4, wrapping modulo 2^XLEN. The accepted address is pushed into the pending-pc FIFO. inflight increments.
- Response arrival:
  - Pops the pending-pc FIFO and decrements inflight.
  - If drop=0: push {cache_rsp_data, pc, pc+4} into the queue.
  - If drop>0: discard the response and decrement drop.
- Simultaneous accept and response in one cycle: inflight is unchanged.
- Decode handshake:
  - A pop occurs when decode_instruction_valid & decode_ready.
  - The head is registered. A response is visible at decode no earlier than the cycle after cache_rsp_valid, so minimum latency is 1 cycle.
  - Output data holds stable while valid & !ready.
- Full queue: no new credit, cache_req_valid=0. Simultaneous push and pop when full is legal, and the count is unchanged.
- Empty queue: decode_instruction_valid=0. Data is don't-care but must not X-propagate.
- Jump (highest priority, same cycle):
  - pc_reg <= jump_addr.
  - Queue flushed, so count=0 next cycle and decode_instruction_valid=0 next cycle.
  - drop <= number of requests outstanding after this cycle's events. A response arriving in the jump cycle itself is discarded and is not added to drop.
  - Pending-pc FIFO entries are not cleared; they are consumed by the dropped responses.
  - cache_req_valid is forced 0 in the jump cycle.
  - A decode pop in the jump cycle is still honoured as a handshake, but its effect is subsumed by the flush.
- Back-to-back jumps: each jump recomputes drop from current inflight. drop never exceeds MAX_OUTSTANDING.
- Reset mid-operation: all state returns to reset values immediately. Responses to requests issued before reset are the cache's responsibility; the cache is reset together with this block.
- Assertions for the bench:
  - cache_rsp_valid with inflight=0 is illegal.
  - A push into a full queue is illegal and must never happen.

Decomposition:
- riscv_isa package: INSTRUCTION and INSTRUCTION_FECHED (existing). Add FETCH_RESET_PC default constant there.
- One natural sub-module, fetch_fifo: a parametrised sync FIFO (WIDTH, DEPTH), with push/pop/flush, full/empty/count, async active-low reset.
  - Instantiated twice: pending-pc FIFO (WIDTH=XLEN, DEPTH=MAX_OUTSTANDING, never flushed) and instruction queue (WIDTH=$bits(INSTRUCTION_FECHED), DEPTH=DEPTH, flushed on jump).
- The top module holds pc_reg, the inflight/drop counters and the credit logic.

Test Plan:
- Streaming: cache_req_ready=1, 1-cycle rsp latency, decode_ready=1 → decode sees pc 0x0,0x4,0x8,... with pc_4 = pc+4, and one instruction per cycle once the pipeline is filled.
- Backpressure: decode_ready=0 for 10 cycles → queue_count saturates at DEPTH=4; inflight + count never exceeds 4; cache_req_valid=0; output data stable. Release → 4 entries drain in order 0x0..0xC.
- Jump with 2 in flight:
  - Setup: jump_addr=0x100 while requests 0x8 and 0xC are pending.
  - Expected: both responses dropped; queue flushed; next decode entry pc=0x100, pc_4=0x104.
- Jump coincident with a response and a decode pop:
  - Setup: assert jump, cache_rsp_valid and decode_instruction_valid & decode_ready in the same cycle.
  - Expected: the arriving response is not enqueued; drop equals the remaining inflight; decode_instruction_valid=0 next cycle.
- Variable latency (random 1-5 cycles, MAX_OUTSTANDING=2) plus random decode_ready → decode pc sequence is strictly +4 between jumps; no loss, duplication or overflow assertion.
- Async reset asserted mid-stream with 2 in flight and 3 queued → all outputs 0 immediately. After release, the first request is to RESET_PC=0x0.
